key_matrix_scanner: RTL and testbench
=====================================

// Module: key_matrix_scanner
// PURPOSE
//  Reader-side counterpart of the row-scanned LED matrix driver: scans an 8x8 switch/key matrix
//  by driving one row low at a time and sampling eight column-sense lines.
//  Synchronizes, debounces per key and presents a stable 8x8 key array plus one-cycle press events.
//  Sits between the board key matrix and the game-of-life cell/seed logic; key_array uses the same
//  [row][col] packing as the LED red/green arrays.
// PARAMETERS
//  ROW_DWELL        16  clock cycles each row is driven; legal range 4..255
//  DEBOUNCE_FRAMES   4  consecutive disagreeing samples before a key's stable state flips; legal 1..15
// PORTS
//  clock        in   1      system clock; all state on posedge
//  reset        in   1      synchronous, active-high reset
//  col_sense    in   8      raw column lines, active-low (0 = key closed on driven row), asynchronous
//  row_drive    out  8      active-low one-hot row select, registered
//  key_array    out  [7:0][7:0]  debounced state, [row][col], 1 = pressed (or toggled, see CONFIGURATION)
//  press_valid  out  1      1-cycle pulse: one or more keys in press_row became pressed
//  press_row    out  3      row index of the press event; valid only while press_valid=1
//  press_cols   out  8      mask of columns newly pressed in press_row; valid only while press_valid=1
//  frame_done   out  1      1-cycle pulse after row 7 has been sampled
// BEHAVIOUR
//  - Reset (sync, reset=1 at posedge): row counter=0, dwell counter=0, row_drive=8'hFE,
//    both sync stages=8'hFF, all debounce counters=0, key_array=0, press_valid=0, press_row=0,
//    press_cols=0, frame_done=0. Reset asserted mid-scan aborts the row; scanning restarts at row 0.
//  - Synchronizer: col_sense passes through 2 flops; sampled value = ~sync2 (1 = closed).
//  - Scan: row r held for ROW_DWELL cycles (dwell 0..ROW_DWELL-1); row_drive = ~(8'b1<<r).
//    Sample taken in dwell cycle ROW_DWELL-1; at that same edge dwell->0 and r->r+1 (7 wraps to 0).
//    Minimum dwell 4 covers 1 cycle of row settle + 2 sync stages.
//  - Debounce, per key (r,c), evaluated only in row r's sample cycle:
//      raw==stable            -> counter <= 0
//      raw!=stable, counter==DEBOUNCE_FRAMES-1 -> stable <= raw, counter <= 0
//      raw!=stable otherwise  -> counter <= counter+1
//    Counter width = 4 bits. Stable change therefore occurs on the Nth consecutive disagreeing
//    frame (DEBOUNCE_FRAMES=1: immediate). A single agreeing sample clears progress.
//  - Events: at the sample edge, press_cols <= mask of keys in row r whose stable goes 0->1;
//    press_valid <= |mask; press_row <= r. Next cycle press_valid returns to 0 (press_row and
//    press_cols hold until the next sample). Releases raise no event. Multiple simultaneous presses
//    in one row -> a single event with multiple mask bits; presses in different rows -> separate events.
//  - key_array updates on the same edge as the event; latency from a stable col_sense change to
//    key_array: at most 8*ROW_DWELL*DEBOUNCE_FRAMES + 3 cycles.
//  - frame_done <= 1 on the edge that samples row 7, else 0. Period is 8*ROW_DWELL cycles.
//  - Ghosting (3-key rectangles) is not corrected; raw samples are used as-is.
// CONFIGURATION
//  CELL_TOGGLE_EN defined: key_array is a cell-edit register; each bit in press_cols
//    flips key_array[press_row][c] on the event edge. Releases do nothing. Debounced level state
//    is kept internally. Reset clears key_array to 0.
//  CELL_TOGGLE_EN undefined: key_array = debounced level state (1 while held). Events unchanged.
// TESTING (bench: ROW_DWELL=4, DEBOUNCE_FRAMES=2, frame=32 cycles)
//  1 Reset, no keys -> row_drive FE,FD,FB..7F each 4 cycles, wraps to FE; frame_done every 32 cycles;
//    key_array=0, press_valid never 1.
//  2 Hold key (2,5) closed from cycle 0 (col_sense[5]=0 whenever row_drive[2]=0) -> exactly one
//    press_valid, press_row=2, press_cols=8'h20 in frame 2 sample; key_array[2][5]=1 until release.
//  3 Key (4,1) closed for one row-4 sample only, then open -> no event, key_array stays 0.
//  4 Keys (6,0),(6,7) closed together -> single event, press_row=6, press_cols=8'h81.
//  5 Reset pulsed while row 3 driven with key (3,3) counting -> row_drive=FE next cycle, all outputs 0,
//    counters restart; key pressed again needs 2 full frames for an event.
//  6 CELL_TOGGLE_EN: press/release key (0,0) twice (each held >=3 frames) -> key_array[0][0] 1 then 0;
//    undefined: key_array[0][0] follows level, 1 only while held.

Source files
------------

// File: rtl/key_matrix_scanner.sv
// 8x8 key matrix scanner: active-low row scan, 2-flop column sync, per-key debounce and press events.
// Define CELL_TOGGLE_EN to make key_array a toggle-on-press cell-edit register instead of the debounced level.
module key_matrix_scanner #(
  parameter int ROW_DWELL       = 16,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [7:0]      col_sense,
  output logic [7:0]      row_drive,
  output logic [7:0][7:0] key_array,
  output logic            press_valid,
  output logic [2:0]      press_row,
  output logic [7:0]      press_cols,
  output logic            frame_done
);

  localparam logic [7:0] DWELL_LAST = 8'(ROW_DWELL - 1);
  localparam logic [3:0] DEB_LAST   = 4'(DEBOUNCE_FRAMES - 1);

  logic [2:0]            row_cnt;
  logic [2:0]            next_row;
  logic [7:0]            dwell_cnt;
  logic                  sample;
  logic [7:0]            sync1;
  logic [7:0]            sync2;
  logic [7:0]            raw;
  logic [7:0][7:0][3:0]  deb_cnt;
  logic [7:0][7:0]       stable;
  logic [7:0]            row_stable_next;
  logic [7:0][3:0]       row_deb_next;
  logic [7:0]            rise_mask;

  assign sample   = (dwell_cnt == DWELL_LAST);
  assign next_row = row_cnt + 3'd1;
  assign raw      = ~sync2;

  always_ff @(posedge clock) begin
    if (reset) begin
      row_cnt   <= 3'd0;
      dwell_cnt <= 8'd0;
      row_drive <= 8'hFE;
    end else if (sample) begin
      row_cnt   <= next_row;
      dwell_cnt <= 8'd0;
      row_drive <= ~(8'b1 << next_row);
    end else begin
      dwell_cnt <= dwell_cnt + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 8'hFF;
      sync2 <= 8'hFF;
    end else begin
      sync1 <= col_sense;
      sync2 <= sync1;
    end
  end

  // Only the currently driven row is evaluated; any agreeing sample wipes that key's progress.
  always_comb begin
    row_stable_next = stable[row_cnt];
    row_deb_next    = '0;
    for (int c = 0; c < 8; c++) begin
      if (raw[c] != stable[row_cnt][c]) begin
        if (deb_cnt[row_cnt][c] == DEB_LAST)
          row_stable_next[c] = raw[c];
        else
          row_deb_next[c] = deb_cnt[row_cnt][c] + 4'd1;
      end
    end
    rise_mask = row_stable_next & ~stable[row_cnt];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      deb_cnt <= '0;
      stable  <= '0;
    end else if (sample) begin
      deb_cnt[row_cnt] <= row_deb_next;
      stable[row_cnt]  <= row_stable_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      press_valid <= 1'b0;
      press_row   <= 3'd0;
      press_cols  <= 8'd0;
      frame_done  <= 1'b0;
    end else begin
      press_valid <= sample && (|rise_mask);
      frame_done  <= sample && (row_cnt == 3'd7);
      if (sample) begin
        press_row  <= row_cnt;
        press_cols <= rise_mask;
      end
    end
  end

`ifdef CELL_TOGGLE_EN
  always_ff @(posedge clock) begin
    if (reset)
      key_array <= '0;
    else if (sample)
      key_array[row_cnt] <= key_array[row_cnt] ^ rise_mask;
  end
`else
  assign key_array = stable;
`endif

endmodule

// File: tb/tb_key_matrix_scanner.sv
// Directed bench for key_matrix_scanner (ROW_DWELL=4, DEBOUNCE_FRAMES=2); k counts posedges after reset release.
module tb_key_matrix_scanner;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [7:0]      col_sense;
  logic [7:0]      row_drive;
  logic [7:0][7:0] key_array;
  logic            press_valid;
  logic [2:0]      press_row;
  logic [7:0]      press_cols;
  logic            frame_done;
  logic [7:0][7:0] keys = '0;
  int              total = 0;
  int              bad = 0;

`ifdef CELL_TOGGLE_EN
  localparam bit TOGGLE = 1'b1;
`else
  localparam bit TOGGLE = 1'b0;
`endif

  key_matrix_scanner #(.ROW_DWELL(4), .DEBOUNCE_FRAMES(2)) dut (
    .clock(clock), .reset(reset), .col_sense(col_sense), .row_drive(row_drive),
    .key_array(key_array), .press_valid(press_valid), .press_row(press_row),
    .press_cols(press_cols), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  // Switch matrix model: a closed key pulls its column low while its row is driven low.
  always_comb begin
    col_sense = 8'hFF;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        if (keys[r][c] && !row_drive[r]) col_sense[c] = 1'b0;
  end

  task automatic do_reset();
    @(negedge clock); reset = 1'b1;
    @(negedge clock);
    @(negedge clock); reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] exp_rd;
    keys = '0;
    do_reset();
    total++; if (row_drive !== 8'hFE) begin bad++; $display("[TB] FAIL reset_row_drive got=%h exp=fe", row_drive); end
    total++; if (key_array !== 64'h0) begin bad++; $display("[TB] FAIL reset_key_array got=%h exp=0", key_array); end
    total++; if (press_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_press_valid got=%b exp=0", press_valid); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_frame_done got=%b exp=0", frame_done); end
    for (int k = 1; k <= 70; k++) begin
      @(negedge clock);
      exp_rd = ~(8'b1 << ((k / 4) % 8));
      total++; if (row_drive !== exp_rd) begin bad++; $display("[TB] FAIL scan_row_drive k=%0d got=%h exp=%h", k, row_drive, exp_rd); end
      total++; if (frame_done !== (k % 32 == 0)) begin bad++; $display("[TB] FAIL scan_frame_done k=%0d got=%b exp=%b", k, frame_done, (k % 32 == 0)); end
      total++; if (press_valid !== 1'b0) begin bad++; $display("[TB] FAIL scan_press_valid k=%0d got=%b exp=0", k, press_valid); end
      total++; if (key_array !== 64'h0) begin bad++; $display("[TB] FAIL scan_key_array k=%0d got=%h exp=0", k, key_array); end
    end
  endtask

  task automatic test_hold_key();
    logic [7:0][7:0] exp_ka;
    keys = '0; keys[2][5] = 1'b1;
    do_reset();
    for (int k = 1; k <= 150; k++) begin
      @(negedge clock);
      total++; if (press_valid !== (k == 44)) begin bad++; $display("[TB] FAIL hold_press_valid k=%0d got=%b exp=%b", k, press_valid, (k == 44)); end
      if (k == 44) begin
        total++; if (press_row !== 3'd2) begin bad++; $display("[TB] FAIL hold_press_row got=%0d exp=2", press_row); end
        total++; if (press_cols !== 8'h20) begin bad++; $display("[TB] FAIL hold_press_cols got=%h exp=20", press_cols); end
      end
      exp_ka = '0;
      exp_ka[2][5] = (k >= 44) && (TOGGLE || k < 140);
      total++; if (key_array !== exp_ka) begin bad++; $display("[TB] FAIL hold_key_array k=%0d got=%h exp=%h", k, key_array, exp_ka); end
      if (k == 80) keys[2][5] = 1'b0;
    end
  endtask

  task automatic test_glitch();
    keys = '0; keys[4][1] = 1'b1;
    do_reset();
    for (int k = 1; k <= 128; k++) begin
      @(negedge clock);
      total++; if (press_valid !== 1'b0) begin bad++; $display("[TB] FAIL glitch_press_valid k=%0d got=%b exp=0", k, press_valid); end
      total++; if (key_array !== 64'h0) begin bad++; $display("[TB] FAIL glitch_key_array k=%0d got=%h exp=0", k, key_array); end
      keys[4][1] = ((k / 32) == 0) || ((k / 32) == 2);
    end
  endtask

  task automatic test_multi_press();
    logic [7:0][7:0] exp_ka;
    keys = '0; keys[6][0] = 1'b1; keys[6][7] = 1'b1;
    do_reset();
    for (int k = 1; k <= 70; k++) begin
      @(negedge clock);
      total++; if (press_valid !== (k == 60)) begin bad++; $display("[TB] FAIL multi_press_valid k=%0d got=%b exp=%b", k, press_valid, (k == 60)); end
      if (k == 60 || k == 61) begin
        total++; if (press_row !== 3'd6) begin bad++; $display("[TB] FAIL multi_press_row k=%0d got=%0d exp=6", k, press_row); end
        total++; if (press_cols !== 8'h81) begin bad++; $display("[TB] FAIL multi_press_cols k=%0d got=%h exp=81", k, press_cols); end
      end
      exp_ka = '0;
      exp_ka[6][0] = (k >= 60);
      exp_ka[6][7] = (k >= 60);
      total++; if (key_array !== exp_ka) begin bad++; $display("[TB] FAIL multi_key_array k=%0d got=%h exp=%h", k, key_array, exp_ka); end
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [7:0][7:0] exp_ka;
    keys = '0; keys[3][3] = 1'b1; keys[1][2] = 1'b1;
    do_reset();
    for (int k = 1; k <= 45; k++) begin
      @(negedge clock);
      total++; if (press_valid !== (k == 40)) begin bad++; $display("[TB] FAIL mid_pre_press_valid k=%0d got=%b exp=%b", k, press_valid, (k == 40)); end
      if (k == 40) begin
        total++; if (press_row !== 3'd1) begin bad++; $display("[TB] FAIL mid_pre_press_row got=%0d exp=1", press_row); end
        total++; if (press_cols !== 8'h04) begin bad++; $display("[TB] FAIL mid_pre_press_cols got=%h exp=04", press_cols); end
      end
    end
    reset = 1'b1;
    @(negedge clock);
    total++; if (row_drive !== 8'hFE) begin bad++; $display("[TB] FAIL mid_row_drive got=%h exp=fe", row_drive); end
    total++; if (key_array !== 64'h0) begin bad++; $display("[TB] FAIL mid_key_array got=%h exp=0", key_array); end
    total++; if (press_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_press_valid got=%b exp=0", press_valid); end
    total++; if (press_row !== 3'd0) begin bad++; $display("[TB] FAIL mid_press_row got=%0d exp=0", press_row); end
    total++; if (press_cols !== 8'h00) begin bad++; $display("[TB] FAIL mid_press_cols got=%h exp=00", press_cols); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("[TB] FAIL mid_frame_done got=%b exp=0", frame_done); end
    reset = 1'b0;
    for (int k = 1; k <= 52; k++) begin
      @(negedge clock);
      total++; if (press_valid !== (k == 40 || k == 48)) begin bad++; $display("[TB] FAIL mid_post_press_valid k=%0d got=%b exp=%b", k, press_valid, (k == 40 || k == 48)); end
      if (k == 40) begin
        total++; if (press_cols !== 8'h04 || press_row !== 3'd1) begin bad++; $display("[TB] FAIL mid_post_ev1 got=row%0d/%h exp=row1/04", press_row, press_cols); end
      end
      if (k == 48) begin
        total++; if (press_cols !== 8'h08 || press_row !== 3'd3) begin bad++; $display("[TB] FAIL mid_post_ev2 got=row%0d/%h exp=row3/08", press_row, press_cols); end
      end
      exp_ka = '0;
      exp_ka[1][2] = (k >= 40);
      exp_ka[3][3] = (k >= 48);
      total++; if (key_array !== exp_ka) begin bad++; $display("[TB] FAIL mid_post_key_array k=%0d got=%h exp=%h", k, key_array, exp_ka); end
    end
  endtask

  task automatic test_toggle();
    logic [7:0][7:0] exp_ka;
    logic            pv;
    keys = '0; keys[0][0] = 1'b1;
    do_reset();
    for (int k = 1; k <= 460; k++) begin
      @(negedge clock);
      pv = (k == 36) || (k == 292);
      total++; if (press_valid !== pv) begin bad++; $display("[TB] FAIL toggle_press_valid k=%0d got=%b exp=%b", k, press_valid, pv); end
      if (pv) begin
        total++; if (press_row !== 3'd0 || press_cols !== 8'h01) begin bad++; $display("[TB] FAIL toggle_event k=%0d got=row%0d/%h exp=row0/01", k, press_row, press_cols); end
      end
      exp_ka = '0;
      exp_ka[0][0] = TOGGLE ? (k >= 36 && k < 292)
                            : ((k >= 36 && k < 164) || (k >= 292 && k < 420));
      total++; if (key_array !== exp_ka) begin bad++; $display("[TB] FAIL toggle_key_array k=%0d got=%h exp=%h", k, key_array, exp_ka); end
      keys[0][0] = ((k / 128) % 2 == 0);
    end
  endtask

  initial begin
    test_reset();
    test_hold_key();
    test_glitch();
    test_multi_press();
    test_reset_mid_scan();
    test_toggle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
